// File: rtl/strided_convolver.sv
// strided_convolver: streams an n x n feature map in row-major order and emits
// the strided k x k correlation with a latched kernel, in fixed-point QN.Q with
// floor shift and saturation to N bits.
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   en_i, weights_i        start pulse (IDLE only) and kernel latched on start
//   act_i, act_valid_i,
//   act_ready_o            activation stream handshake
//   conv_o, val_conv_o,
//   out_ready_i            result stream handshake
//   done_conv_o            one-cycle frame-complete pulse
module strided_convolver #(
  parameter int unsigned n = 5,
  parameter int unsigned k = 3,
  parameter int unsigned S = 1,
  parameter int unsigned N = 16,
  parameter int unsigned Q = 12
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [k*k*N-1:0] weights_i,
  input  logic [N-1:0]     act_i,
  input  logic             act_valid_i,
  output logic             act_ready_o,
  output logic [N-1:0]     conv_o,
  output logic             val_conv_o,
  input  logic             out_ready_i,
  output logic             done_conv_o
);

  localparam int unsigned NN    = n * n;
  localparam int unsigned WIN_L = (k - 1) * n + k;
  localparam int unsigned ACC_W = 2 * N + $clog2(k * k);
  localparam int unsigned CNT_W = $clog2(NN + 1);
  localparam int unsigned RC_W  = $clog2(n + 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                      state_q;
  logic [k*k*N-1:0]            w_q;
  // The window buffer is WIN_L entries long; its newest entry is the beat being
  // accepted (act_i), so only WIN_L-1 entries need to be registered.
  logic [WIN_L-2:0][N-1:0]     win_q;
  logic [RC_W-1:0]             row_q;
  logic [RC_W-1:0]             col_q;
  logic [CNT_W-1:0]            cnt_q;
  logic [N-1:0]                conv_q;
  logic                        val_q;
  logic                        done_q;

  logic [WIN_L-1:0][N-1:0]     win_all_c;
  logic                        accept_c;
  logic                        win_done_c;
  logic [RC_W-1:0]             row_d;
  logic [RC_W-1:0]             col_d;
  logic signed [2*N-1:0]       prod_c [k*k];
  logic signed [ACC_W-1:0]     psum_c [k*k+1];
  logic signed [ACC_W-1:0]     shifted_c;
  logic [N-1:0]                sat_c;

  assign conv_o      = conv_q;
  assign val_conv_o  = val_q;
  assign done_conv_o = done_q;

  // Ready depends on out_ready_i so a consumed result can be replaced in the same cycle.
  assign act_ready_o = (state_q == RUN) && (cnt_q < CNT_W'(NN)) && (!val_q || out_ready_i);
  assign accept_c    = act_valid_i && act_ready_o;

  // Entry j is the activation j beats older than the current one.
  assign win_all_c = {win_q, act_i};

  // Kernel element (r,c) pairs with the activation (k-1-r) rows and (k-1-c) columns back.
  for (genvar r = 0; r < k; r++) begin : g_row
    for (genvar c = 0; c < k; c++) begin : g_col
      localparam int unsigned OFF = (k - 1 - r) * n + (k - 1 - c);
      localparam int unsigned IDX = r * k + c;
      assign prod_c[IDX] = $signed(win_all_c[OFF]) * $signed(w_q[IDX*N +: N]);
      assign psum_c[IDX+1] = psum_c[IDX] + ACC_W'(prod_c[IDX]);
    end
  end
  assign psum_c[0] = '0;

  // Floor shift, then clamp to the N-bit two's complement range.
  always_comb begin
    shifted_c = psum_c[k*k] >>> Q;
    if (shifted_c > SAT_MAX) begin
      sat_c = SAT_MAX[N-1:0];
    end else if (shifted_c < SAT_MIN) begin
      sat_c = SAT_MIN[N-1:0];
    end else begin
      sat_c = shifted_c[N-1:0];
    end
  end

  // Window completion at the current (row,col) honouring the stride in both axes.
  always_comb begin
    win_done_c = (int'(row_q) >= int'(k) - 1) && (int'(col_q) >= int'(k) - 1);
    if (win_done_c) begin
      win_done_c = ((int'(row_q) - int'(k) + 1) % int'(S) == 0) &&
                   ((int'(col_q) - int'(k) + 1) % int'(S) == 0);
    end
  end

  // Raster position of the next beat.
  always_comb begin
    row_d = row_q;
    col_d = col_q + RC_W'(1);
    if (col_q == RC_W'(n - 1)) begin
      col_d = '0;
      row_d = row_q + RC_W'(1);
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      w_q     <= '0;
      win_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      conv_q  <= '0;
      val_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en_i) begin
            state_q <= RUN;
            w_q     <= weights_i;
            win_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            val_q   <= 1'b0;
          end
        end
        RUN: begin
          if (accept_c) begin
            win_q <= win_all_c[WIN_L-2:0];
            row_q <= row_d;
            col_q <= col_d;
            cnt_q <= cnt_q + CNT_W'(1);
          end
          if (accept_c && win_done_c) begin
            conv_q <= sat_c;
            val_q  <= 1'b1;
          end else if (val_q && out_ready_i) begin
            val_q <= 1'b0;
          end
          // Frame ends once every beat is in and the last result is consumed.
          if ((cnt_q == CNT_W'(NN)) && (!val_q || out_ready_i)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_strided_convolver.sv
// tb_strided_convolver: directed, table-driven checks of strided_convolver with
// a stride-1 and a stride-2 instance sharing the data inputs.
module tb_strided_convolver;

  localparam int unsigned NW = 16;
  localparam int unsigned KS = 3;
  localparam int unsigned NS = 5;

  typedef struct {
    int          which;
    logic [15:0] w;
    int          mode;
    int          nexp;
    logic [15:0] exp [9];
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [KS*KS*NW-1:0]  wgts;
  logic [NW-1:0]        act;
  logic                 en    [2];
  logic                 valid [2];
  logic                 ordy  [2];
  logic                 ready [2];
  logic                 val   [2];
  logic                 done  [2];
  logic [NW-1:0]        conv  [2];

  int          checks = 0;
  int          errors = 0;
  logic [15:0] got_q [$];
  int          got_done;
  vec_t        vec [3];

  always #5 clk = ~clk;

  strided_convolver #(.n(NS), .k(KS), .S(1), .N(NW), .Q(12)) u_s1 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en[0]), .weights_i(wgts),
    .act_i(act), .act_valid_i(valid[0]), .act_ready_o(ready[0]),
    .conv_o(conv[0]), .val_conv_o(val[0]), .out_ready_i(ordy[0]),
    .done_conv_o(done[0])
  );

  strided_convolver #(.n(NS), .k(KS), .S(2), .N(NW), .Q(12)) u_s2 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en[1]), .weights_i(wgts),
    .act_i(act), .act_valid_i(valid[1]), .act_ready_o(ready[1]),
    .conv_o(conv[1]), .val_conv_o(val[1]), .out_ready_i(ordy[1]),
    .done_conv_o(done[1])
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Runs one frame on instance 'which'. Optional: stall the output for
  // stall_cycles after the first result, pulse en_i with other weights at beat
  // glitch_at, or assert reset once abort_at beats are accepted.
  task automatic run_frame(input int which, input logic [15:0] w, input int mode,
                           input int stall_cycles, input int glitch_at, input int abort_at);
    int beats, cyc, post, stall_left, bad;
    bit stall_started, glitched, fin, acc;
    got_q.delete();
    got_done = 0;
    beats = 0; cyc = 0; post = 0; stall_left = 0; bad = 0;
    stall_started = 0; glitched = 0; fin = 0;
    @(negedge clk);
    wgts = {9{w}};
    en[which] = 1'b1;
    @(negedge clk);
    en[which] = 1'b0;
    wgts = {9{16'h5A5A}};
    while (!fin) begin
      valid[which] = (beats < 25);
      act = (mode == 0) ? 16'(beats * 256) : 16'h7FFF;
      ordy[which] = (stall_left == 0);
      if (glitch_at == beats && !glitched) begin
        en[which] = 1'b1;
        wgts = {9{16'h2000}};
        glitched = 1;
      end else begin
        en[which] = 1'b0;
      end
      if (abort_at == beats) begin
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_conv", 32'(conv[which]), 32'h0);
        check("abort_val", 32'(val[which]), 32'h0);
        check("abort_done", 32'(done[which]), 32'h0);
        check("abort_ready", 32'(ready[which]), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (val[which] || done[which] || ready[which]) bad++;
        end
        check("abort_quiet", 32'(bad), 32'h0);
        fin = 1;
      end else begin
        #1;
        if (stall_cycles > 0 && !stall_started && val[which]) begin
          stall_started = 1;
          stall_left = stall_cycles;
          ordy[which] = 1'b0;
          #1;
        end
        if (stall_left > 0) begin
          check($sformatf("stall_ready_%0d", stall_left), 32'(ready[which]), 32'h0);
          check($sformatf("stall_conv_%0d", stall_left), 32'(conv[which]), 32'h3600);
          stall_left--;
        end
        if (val[which] && ordy[which]) got_q.push_back(conv[which]);
        if (done[which]) got_done++;
        acc = valid[which] && ready[which];
        @(negedge clk);
        if (acc) beats++;
        if (beats == 25 && got_done > 0) post++;
        if (post > 3) fin = 1;
        cyc++;
        if (cyc > 300) begin
          check("frame_timeout", 32'h1, 32'h0);
          fin = 1;
        end
      end
    end
    valid[which] = 1'b0;
    ordy[which] = 1'b1;
    en[which] = 1'b0;
  endtask

  task automatic compare_frame(input string tag, input int idx);
    check($sformatf("%s_count", tag), 32'(got_q.size()), 32'(vec[idx].nexp));
    for (int j = 0; j < vec[idx].nexp; j++) begin
      if (j < got_q.size())
        check($sformatf("%s_out%0d", tag, j), 32'(got_q[j]), 32'(vec[idx].exp[j]));
      else
        check($sformatf("%s_out%0d", tag, j), 32'hFFFF_FFFF, 32'(vec[idx].exp[j]));
    end
    check($sformatf("%s_done", tag), 32'(got_done), 32'h1);
  endtask

  initial begin
    // Window sums are 9*centre index of i*0x100 activations with unit weights.
    vec[0].which = 0; vec[0].w = 16'h1000; vec[0].mode = 0; vec[0].nexp = 9;
    vec[0].exp = '{16'h3600, 16'h3F00, 16'h4800, 16'h6300, 16'h6C00,
                   16'h7500, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    vec[1].which = 1; vec[1].w = 16'h1000; vec[1].mode = 0; vec[1].nexp = 4;
    vec[1].exp = '{16'h3600, 16'h4800, 16'h7FFF, 16'h7FFF, 16'h0000,
                   16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vec[2].which = 0; vec[2].w = 16'hF000; vec[2].mode = 1; vec[2].nexp = 9;
    vec[2].exp = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                   16'h8000, 16'h8000, 16'h8000, 16'h8000};

    rst_n = 1'b0;
    wgts = '0;
    act = '0;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; valid[i] = 1'b0; ordy[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_conv%0d", i), 32'(conv[i]), 32'h0);
      check($sformatf("rst_val%0d", i), 32'(val[i]), 32'h0);
      check($sformatf("rst_done%0d", i), 32'(done[i]), 32'h0);
      check($sformatf("rst_ready%0d", i), 32'(ready[i]), 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 3; v++) begin
      run_frame(vec[v].which, vec[v].w, vec[v].mode, 0, -1, -1);
      compare_frame($sformatf("vec%0d", v), v);
    end

    run_frame(0, 16'h1000, 0, 10, -1, -1);
    compare_frame("stall", 0);

    run_frame(0, 16'h1000, 0, 0, -1, 12);
    run_frame(0, 16'h1000, 0, 0, -1, -1);
    compare_frame("restart", 0);

    run_frame(0, 16'h1000, 0, 0, 5, -1);
    compare_frame("en_in_run", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
